// File: rtl/npu_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : npu_input_fifo
//  Purpose  : Operand-word buffer between the Processor NPU input port and
//             the NPU compute core. Write side is back-pressured by full;
//             read side is first-word-fall-through. Exposes occupancy and
//             sticky overflow/underflow debug flags.
//  Revision : 1.0 - initial release
// ============================================================================
module npu_input_fifo #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    // Occupancy thresholds expressed at count width so comparisons are exact.
    localparam logic [ADDR_W:0] c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_AFULL_CNT = (ADDR_W+1)'(AFULL_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_afull;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_count_nxt;

    // Requests are qualified against the registered flags, never the next state.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    // Next occupancy: a simultaneous accepted write and read cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // Storage is not cleared on reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and sticky error flags.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            r_afull <= (w_count_nxt >= c_AFULL_CNT);
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Head word falls through combinationally; forced to zero when empty.
    assign rd_data     = r_empty ? '0 : r_mem[r_rd_ptr];
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_afull;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_npu_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_npu_input_fifo
//  Purpose  : Self-checking bench for npu_input_fifo using a queue-based
//             reference model, directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_npu_input_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        full;
    logic        almost_full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    npu_input_fifo #(
        .DATA_W       (32),
        .DEPTH        (DEPTH),
        .ADDR_W       (4),
        .AFULL_THRESH (14)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: plain queue of stored words plus sticky error bits.
    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update on every rising edge, using the occupancy before the edge.
    always @(posedge clk) begin
        int sz;
        sz = q.size();
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (wr_en && sz == DEPTH) m_ovf = 1'b1;
            if (rd_en && sz == 0)     m_udf = 1'b1;
            if (rd_en && sz != 0)     void'(q.pop_front());
            if (wr_en && sz != DEPTH) q.push_back(wr_data);
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("count",       32'(count),       32'(q.size()));
            chk("empty",       32'(empty),       32'(q.size() == 0));
            chk("full",        32'(full),        32'(q.size() == DEPTH));
            chk("almost_full", 32'(almost_full), 32'(q.size() >= 14));
            chk("rd_data",     rd_data,          (q.size() != 0) ? q[0] : 32'h0);
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("underflow",   32'(underflow),   32'(m_udf));
        end
    end

    task automatic cyc(input logic we, input logic [31:0] wd, input logic re);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 32'h5555_AAAA;

        // 1. Reset held for 3 clocks with both requests asserted.
        repeat (3) cyc(1'b1, 32'h5555_AAAA, 1'b1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_udf",   32'(underflow), 32'd0);
        chk("rst_rdata", rd_data, 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 2. Fill with 16 words.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
        end
        chk("fill_full", 32'(full), 32'd1);
        cyc(1'b1, 32'hBAD0_0000, 1'b0);
        chk("ovf_set",    32'(overflow), 32'd1);
        chk("ovf_count",  32'(count),    32'd16);

        // 3. Drain all 16 words in order.
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", rd_data, 32'h1000_0000 + 32'(i));
            cyc(1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("udf_set", 32'(underflow), 32'd1);

        // 4. Preload 3 words, then 40 concurrent write/read cycles.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, $urandom, 1'b1);
            chk("wrap_count", 32'(count), 32'd3);
        end

        // 5a. Concurrent write+read while full.
        while (count < 5'd16) cyc(1'b1, $urandom, 1'b0);
        cyc(1'b1, 32'hFFFF_0001, 1'b1);
        chk("full_wr_rd_count", 32'(count), 32'd15);
        chk("full_wr_rd_full",  32'(full),  32'd0);

        // 5b. Concurrent write+read while empty.
        while (count != 5'd0) cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'hABCD_1234, 1'b1);
        chk("empty_wr_rd_count", 32'(count), 32'd1);
        chk("empty_wr_rd_data",  rd_data, 32'hABCD_1234);

        // 6. Mid-operation reset at count 9.
        while (count < 5'd9) cyc(1'b1, $urandom, 1'b0);
        rst_n = 1'b0;
        cyc(1'b1, 32'h1111_1111, 1'b1);
        rst_n = 1'b1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_ovf",   32'(overflow), 32'd0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("midrst_first", rd_data, 32'hDEAD_BEEF);

        // 7. Randomized traffic with varying write/read bias and rare resets.
        for (int i = 0; i < 3000; i++) begin
            int phase;
            phase = (i / 300) % 3;
            rst_n = ($urandom_range(0, 199) != 0);
            case (phase)
                0:       cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
                1:       cyc($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 3) != 0);
                default: cyc($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);
            endcase
        end
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
